// File: rtl/tri_setup_pkg.sv
// Shared types, constants and helpers for the triangle setup stage.
package tri_setup_pkg;

    // Processing sequence for one triangle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDGE   = 3'd1,
        S_CULL   = 3'd2,
        S_OUTPUT = 3'd3,
        S_HOLD   = 3'd4
    } state_e;

    localparam int FRAC_BITS      = 16;
    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_GUARD_BITS = 12;

    // Truncate a 16.16 value to its integer part (floor) and saturate it to
    // the signed guard_bits range, returned sign-extended to 16 bits.
    function automatic logic signed [15:0] fx_to_int_sat(
        input logic signed [31:0] fx,
        input int                 guard_bits
    );
        int ip;
        int hi;
        int lo;
        ip = int'(fx) >>> FRAC_BITS;
        hi = (32'sd1 <<< (guard_bits - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (ip > hi) begin
            ip = hi;
        end else if (ip < lo) begin
            ip = lo;
        end else begin
            ip = ip;
        end
        return ip[15:0];
    endfunction

    // Clamp a signed coordinate into [0, hi].
    function automatic logic signed [15:0] clamp_coord(
        input logic signed [15:0] v,
        input logic signed [15:0] hi
    );
        logic signed [15:0] r;
        if (v < 16'sd0) begin
            r = 16'sd0;
        end else if (v > hi) begin
            r = hi;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/tri_setup_edge_setup.sv
// Edge function coefficients for the directed edge from vertex i to vertex j:
//   A = yi - yj, B = xj - xi, C = xi*yj - xj*yi (all 32-bit signed).
module edge_setup
    import tri_setup_pkg::*;
(
    input  logic signed [15:0] xi_i,
    input  logic signed [15:0] yi_i,
    input  logic signed [15:0] xj_i,
    input  logic signed [15:0] yj_i,
    output logic signed [31:0] a_o,
    output logic signed [31:0] b_o,
    output logic signed [31:0] c_o
);

    logic signed [31:0] xi_e;
    logic signed [31:0] yi_e;
    logic signed [31:0] xj_e;
    logic signed [31:0] yj_e;

    // Sign-extend the vertices and form the three coefficients.
    always_comb begin
        xi_e = {{16{xi_i[15]}}, xi_i};
        yi_e = {{16{yi_i[15]}}, yi_i};
        xj_e = {{16{xj_i[15]}}, xj_i};
        yj_e = {{16{yj_i[15]}}, yj_i};
        a_o  = yi_e - yj_e;
        b_o  = xj_e - xi_e;
        c_o  = (xi_e * yj_e) - (xj_e * yi_e);
    end

endmodule

// File: rtl/tri_setup.sv
// Triangle setup stage: integer vertex conversion, edge functions, doubled
// signed area, clamped bounding box and culling, with valid/stall handshake
// on both sides.
// Build option: TRI_SETUP_BACKFACE_CULL_EN -- when defined, triangles with
// negative area are culled; otherwise they are flipped to positive area.
module tri_setup
    import tri_setup_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int GUARD_BITS = DEF_GUARD_BITS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] x_in [0:3],
    input  logic signed [31:0] y_in [0:3],
    input  logic        [31:0] z_in [0:3],
    input  logic        [23:0] color_in1,
    input  logic        [23:0] color_in2,
    input  logic        [23:0] color_in3,
    input  logic               input_data_valid,
    input  logic               done_in,
    input  logic               stall_in,
    output logic               stall_out,
    output logic signed [15:0] vx_out [0:2],
    output logic signed [15:0] vy_out [0:2],
    output logic        [31:0] vz_out [0:2],
    output logic        [23:0] color_out1,
    output logic        [23:0] color_out2,
    output logic        [23:0] color_out3,
    output logic signed [31:0] edge_a [0:2],
    output logic signed [31:0] edge_b [0:2],
    output logic signed [31:0] edge_c [0:2],
    output logic signed [31:0] area2,
    output logic signed [15:0] bb_xmin,
    output logic signed [15:0] bb_xmax,
    output logic signed [15:0] bb_ymin,
    output logic signed [15:0] bb_ymax,
    output logic               token_only,
    output logic               out_data_valid,
    output logic               done_out
);

    localparam logic signed [15:0] X_MAX = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] Y_MAX = 16'(SCREEN_H - 1);
    localparam logic signed [15:0] X_LIM = 16'(SCREEN_W);
    localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H);

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               stall_q, stall_d;
    logic               valid_q, valid_d;
    logic               token_q, token_d;
    logic               doneo_q, doneo_d;

    logic signed [15:0] vx_q [0:2];
    logic signed [15:0] vy_q [0:2];
    logic        [31:0] vz_q [0:2];
    logic        [23:0] col1_q, col2_q, col3_q;
    logic               done_q;
    logic signed [31:0] ea_q [0:2];
    logic signed [31:0] eb_q [0:2];
    logic signed [31:0] ec_q [0:2];
    logic signed [31:0] area_q;
    logic signed [15:0] bbx0_q, bbx1_q, bby0_q, bby1_q;
    logic               cull_q;

    logic signed [15:0] exi_s, eyi_s, exj_s, eyj_s;
    logic signed [31:0] a_s, b_s, c_s;
    logic signed [15:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic               offscreen_s;
    logic               cull_s;
    logic               accept_s;
    logic               unused_in_s;

    // The fourth vertex slot is never part of a triangle.
    assign unused_in_s = ^{x_in[3], y_in[3], z_in[3]};

    assign accept_s = input_data_valid && !stall_q;

    // Route the current edge's vertex pair (i, (i+1)%3) to the shared edge unit.
    always_comb begin
        case (idx_q)
            2'd0: begin
                exi_s = vx_q[0]; eyi_s = vy_q[0];
                exj_s = vx_q[1]; eyj_s = vy_q[1];
            end
            2'd1: begin
                exi_s = vx_q[1]; eyi_s = vy_q[1];
                exj_s = vx_q[2]; eyj_s = vy_q[2];
            end
            default: begin
                exi_s = vx_q[2]; eyi_s = vy_q[2];
                exj_s = vx_q[0]; eyj_s = vy_q[0];
            end
        endcase
    end

    edge_setup u_edge (
        .xi_i (exi_s),
        .yi_i (eyi_s),
        .xj_i (exj_s),
        .yj_i (eyj_s),
        .a_o  (a_s),
        .b_o  (b_s),
        .c_o  (c_s)
    );

    // Unclamped bounding box and the cull decision taken in S_CULL.
    always_comb begin
        xmin_s = vx_q[0];
        xmax_s = vx_q[0];
        ymin_s = vy_q[0];
        ymax_s = vy_q[0];
        for (int k = 1; k < 3; k++) begin
            if (vx_q[k] < xmin_s) begin xmin_s = vx_q[k]; end else begin xmin_s = xmin_s; end
            if (vx_q[k] > xmax_s) begin xmax_s = vx_q[k]; end else begin xmax_s = xmax_s; end
            if (vy_q[k] < ymin_s) begin ymin_s = vy_q[k]; end else begin ymin_s = ymin_s; end
            if (vy_q[k] > ymax_s) begin ymax_s = vy_q[k]; end else begin ymax_s = ymax_s; end
        end
        offscreen_s = (xmax_s < 16'sd0) || (xmin_s >= X_LIM) ||
                      (ymax_s < 16'sd0) || (ymin_s >= Y_LIM);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        cull_s = (area_q == 32'sd0) || (area_q < 32'sd0) || offscreen_s;
`else
        cull_s = (area_q == 32'sd0) || offscreen_s;
`endif
    end

    // Next-state and handshake/flag decisions for the control FSM.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stall_d = stall_q;
        valid_d = valid_q;
        token_d = token_q;
        doneo_d = doneo_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    stall_d = 1'b1;
                    idx_d   = 2'd0;
                    state_d = S_EDGE;
                end else begin
                    stall_d = 1'b0;
                end
            end
            S_EDGE: begin
                if (idx_q == 2'd2) begin
                    state_d = S_CULL;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_CULL: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (!cull_q) begin
                    valid_d = 1'b1;
                    token_d = 1'b0;
                    doneo_d = done_q;
                    state_d = S_HOLD;
                end else if (done_q) begin
                    valid_d = 1'b1;
                    token_d = 1'b1;
                    doneo_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (!stall_in) begin
                    valid_d = 1'b0;
                    token_d = 1'b0;
                    stall_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
                stall_d = 1'b0;
                valid_d = 1'b0;
                token_d = 1'b0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            token_q <= 1'b0;
            doneo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            token_q <= token_d;
            doneo_q <= doneo_d;
        end
    end

    // Datapath: capture, edge accumulation, bbox/cull and orientation fix-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                vx_q[k] <= 16'sd0;
                vy_q[k] <= 16'sd0;
                vz_q[k] <= 32'd0;
                ea_q[k] <= 32'sd0;
                eb_q[k] <= 32'sd0;
                ec_q[k] <= 32'sd0;
            end
            col1_q <= 24'd0;
            col2_q <= 24'd0;
            col3_q <= 24'd0;
            done_q <= 1'b0;
            area_q <= 32'sd0;
            bbx0_q <= 16'sd0;
            bbx1_q <= 16'sd0;
            bby0_q <= 16'sd0;
            bby1_q <= 16'sd0;
            cull_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        for (int k = 0; k < 3; k++) begin
                            vx_q[k] <= fx_to_int_sat(x_in[k], GUARD_BITS);
                            vy_q[k] <= fx_to_int_sat(y_in[k], GUARD_BITS);
                            vz_q[k] <= z_in[k];
                        end
                        col1_q <= color_in1;
                        col2_q <= color_in2;
                        col3_q <= color_in3;
                        done_q <= done_in;
                        area_q <= 32'sd0;
                    end
                end
                S_EDGE: begin
                    area_q <= area_q + c_s;
                    for (int k = 0; k < 3; k++) begin
                        if (idx_q == 2'(k)) begin
                            ea_q[k] <= a_s;
                            eb_q[k] <= b_s;
                            ec_q[k] <= c_s;
                        end
                    end
                end
                S_CULL: begin
                    bbx0_q <= clamp_coord(xmin_s, X_MAX);
                    bbx1_q <= clamp_coord(xmax_s, X_MAX);
                    bby0_q <= clamp_coord(ymin_s, Y_MAX);
                    bby1_q <= clamp_coord(ymax_s, Y_MAX);
                    cull_q <= cull_s;
`ifndef TRI_SETUP_BACKFACE_CULL_EN
                    // Flip clockwise triangles so the rasterizer always sees area2 > 0.
                    if (area_q < 32'sd0) begin
                        area_q <= -area_q;
                        for (int k = 0; k < 3; k++) begin
                            ea_q[k] <= -ea_q[k];
                            eb_q[k] <= -eb_q[k];
                            ec_q[k] <= -ec_q[k];
                        end
                    end
`endif
                end
                default: begin
                    cull_q <= cull_q;
                end
            endcase
        end
    end

    assign stall_out      = stall_q;
    assign out_data_valid = valid_q;
    assign token_only     = token_q;
    assign done_out       = doneo_q;
    assign vx_out         = vx_q;
    assign vy_out         = vy_q;
    assign vz_out         = vz_q;
    assign color_out1     = col1_q;
    assign color_out2     = col2_q;
    assign color_out3     = col3_q;
    assign edge_a         = ea_q;
    assign edge_b         = eb_q;
    assign edge_c         = ec_q;
    assign area2          = area_q;
    assign bb_xmin        = bbx0_q;
    assign bb_xmax        = bbx1_q;
    assign bb_ymin        = bby0_q;
    assign bb_ymax        = bby1_q;

endmodule

// File: tb/tb_tri_setup.sv
// Directed self-checking bench for tri_setup.
module tb_tri_setup;

    logic               clock = 1'b0;
    logic               reset;
    logic signed [31:0] x_in [0:3];
    logic signed [31:0] y_in [0:3];
    logic        [31:0] z_in [0:3];
    logic        [23:0] color_in1, color_in2, color_in3;
    logic               input_data_valid, done_in, stall_in;
    logic               stall_out;
    logic signed [15:0] vx_out [0:2];
    logic signed [15:0] vy_out [0:2];
    logic        [31:0] vz_out [0:2];
    logic        [23:0] color_out1, color_out2, color_out3;
    logic signed [31:0] edge_a [0:2];
    logic signed [31:0] edge_b [0:2];
    logic signed [31:0] edge_c [0:2];
    logic signed [31:0] area2;
    logic signed [15:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic               token_only, out_data_valid, done_out;

    int tests_run    = 0;
    int tests_failed = 0;

    tri_setup dut (
        .clock(clock), .reset(reset),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .color_in1(color_in1), .color_in2(color_in2), .color_in3(color_in3),
        .input_data_valid(input_data_valid), .done_in(done_in), .stall_in(stall_in),
        .stall_out(stall_out),
        .vx_out(vx_out), .vy_out(vy_out), .vz_out(vz_out),
        .color_out1(color_out1), .color_out2(color_out2), .color_out3(color_out3),
        .edge_a(edge_a), .edge_b(edge_b), .edge_c(edge_c),
        .area2(area2),
        .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
        .token_only(token_only), .out_data_valid(out_data_valid), .done_out(done_out)
    );

    always #5 clock = ~clock;

    // Drive one triangle (integer pixel coords) and hold valid for one edge.
    task automatic accept_tri(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2, input logic done);
        x_in[0] = 32'(x0 * 65536); y_in[0] = 32'(y0 * 65536);
        x_in[1] = 32'(x1 * 65536); y_in[1] = 32'(y1 * 65536);
        x_in[2] = 32'(x2 * 65536); y_in[2] = 32'(y2 * 65536);
        x_in[3] = 32'sd0;          y_in[3] = 32'sd0;
        for (int i = 0; i < 4; i++) z_in[i] = 32'h0000_1000 + 32'(i);
        color_in1 = 24'hFF0000; color_in2 = 24'h00FF00; color_in3 = 24'h0000FF;
        done_in = done;
        input_data_valid = 1'b1;
        @(posedge clock); #1;
        input_data_valid = 1'b0;
        done_in = 1'b0;
    endtask

    // Count edges until out_data_valid is seen, bounded by budget.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (n < budget && out_data_valid !== 1'b1) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({stall_out, out_data_valid, done_out, token_only} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 0000", {stall_out, out_data_valid, done_out, token_only});
        end
        tests_run++;
        if (area2 !== 32'sd0 || bb_xmax !== 16'sd0 || vx_out[0] !== 16'sd0 || edge_c[1] !== 32'sd0) begin
            tests_failed++;
            $display("FAIL reset_data: area2=%0d bb_xmax=%0d vx0=%0d c1=%0d expected all 0", area2, bb_xmax, vx_out[0], edge_c[1]);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic(input string tag);
        int n;
        int ea [3];
        int eb [3];
        int ec [3];
        ea = '{0, -10, 10}; eb = '{10, -10, 0}; ec = '{-100, 300, -100};
        accept_tri(10, 10, 20, 10, 10, 20, 1'b0);
        tests_run++;
        if (stall_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_stall_busy: got %b expected 1", tag, stall_out);
        end
        wait_valid(12, n);
        tests_run++;
        if (n !== 5 || out_data_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d edges valid=%b expected 5 valid=1", tag, n, out_data_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (edge_a[i] !== ea[i] || edge_b[i] !== eb[i] || edge_c[i] !== ec[i]) begin
                tests_failed++;
                $display("FAIL %s_edge%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", tag, i,
                         edge_a[i], edge_b[i], edge_c[i], ea[i], eb[i], ec[i]);
            end
        end
        tests_run++;
        if (area2 !== 32'sd100) begin
            tests_failed++;
            $display("FAIL %s_area2: got %0d expected 100", tag, area2);
        end
        tests_run++;
        if (bb_xmin !== 16'sd10 || bb_xmax !== 16'sd20 || bb_ymin !== 16'sd10 || bb_ymax !== 16'sd20) begin
            tests_failed++;
            $display("FAIL %s_bbox: got %0d..%0d,%0d..%0d expected 10..20,10..20", tag, bb_xmin, bb_xmax, bb_ymin, bb_ymax);
        end
        tests_run++;
        if (token_only !== 1'b0 || done_out !== 1'b0 || vx_out[1] !== 16'sd20 || vy_out[2] !== 16'sd20 ||
            vz_out[1] !== 32'h0000_1001 || color_out2 !== 24'h00FF00) begin
            tests_failed++;
            $display("FAIL %s_passthru: tok=%b done=%b vx1=%0d vy2=%0d vz1=%h c2=%h", tag,
                     token_only, done_out, vx_out[1], vy_out[2], vz_out[1], color_out2);
        end
        @(posedge clock); #1;
        tests_run++;
        if (out_data_valid !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_release: valid=%b stall=%b expected 0 0", tag, out_data_valid, stall_out);
        end
    endtask

    task automatic test_backface();
        int n;
        accept_tri(10, 10, 10, 20, 20, 10, 1'b0);
        wait_valid(12, n);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
        tests_run++;
        if (n !== 12 || out_data_valid !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL backface_drop: edges=%0d valid=%b stall=%b expected 12 0 0", n, out_data_valid, stall_out);
        end
`else
        tests_run++;
        if (n !== 5 || area2 !== 32'sd100) begin
            tests_failed++;
            $display("FAIL backface_flip: edges=%0d area2=%0d expected 5 100", n, area2);
        end
        tests_run++;
        if (edge_a[0] !== 32'sd10 || edge_b[0] !== 32'sd0 || edge_c[0] !== -32'sd100 ||
            edge_a[1] !== -32'sd10 || edge_b[1] !== -32'sd10 || edge_c[1] !== 32'sd300 ||
            edge_a[2] !== 32'sd0 || edge_b[2] !== 32'sd10 || edge_c[2] !== -32'sd100) begin
            tests_failed++;
            $display("FAIL backface_coeffs: e0=%0d/%0d/%0d e1=%0d/%0d/%0d e2=%0d/%0d/%0d expected 10/0/-100 -10/-10/300 0/10/-100",
                     edge_a[0], edge_b[0], edge_c[0], edge_a[1], edge_b[1], edge_c[1], edge_a[2], edge_b[2], edge_c[2]);
        end
        @(posedge clock); #1;
`endif
    endtask

    task automatic test_token();
        int n;
        accept_tri(0, 0, 5, 5, 10, 10, 1'b1);
        wait_valid(12, n);
        tests_run++;
        if (n !== 5 || token_only !== 1'b1 || done_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL token_beat: edges=%0d tok=%b done=%b expected 5 1 1", n, token_only, done_out);
        end
        @(posedge clock); #1;
        tests_run++;
        if (out_data_valid !== 1'b0 || token_only !== 1'b0) begin
            tests_failed++;
            $display("FAIL token_single: valid=%b tok=%b expected 0 0", out_data_valid, token_only);
        end
    endtask

    task automatic test_clamp();
        int n;
        accept_tri(600, 100, 700, 100, 600, 200, 1'b0);
        wait_valid(12, n);
        tests_run++;
        if (n !== 5 || area2 !== 32'sd10000) begin
            tests_failed++;
            $display("FAIL clamp_area: edges=%0d area2=%0d expected 5 10000", n, area2);
        end
        tests_run++;
        if (bb_xmin !== 16'sd600 || bb_xmax !== 16'sd639 || bb_ymin !== 16'sd100 || bb_ymax !== 16'sd200) begin
            tests_failed++;
            $display("FAIL clamp_bbox: got %0d..%0d,%0d..%0d expected 600..639,100..200", bb_xmin, bb_xmax, bb_ymin, bb_ymax);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_offscreen();
        int n;
        accept_tri(640, 0, 700, 0, 640, 50, 1'b0);
        wait_valid(12, n);
        tests_run++;
        if (n !== 12 || out_data_valid !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL offscreen_cull: edges=%0d valid=%b stall=%b expected 12 0 0", n, out_data_valid, stall_out);
        end
    endtask

    task automatic test_saturate_hold();
        int n;
        stall_in = 1'b1;
        accept_tri(-3000, 0, 10, 0, 10, 10, 1'b0);
        wait_valid(12, n);
        tests_run++;
        if (n !== 5 || vx_out[0] !== -16'sd2048 || area2 !== 32'sd20580 || bb_xmin !== 16'sd0) begin
            tests_failed++;
            $display("FAIL sat_values: edges=%0d vx0=%0d area2=%0d bb_xmin=%0d expected 5 -2048 20580 0",
                     n, vx_out[0], area2, bb_xmin);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            tests_run++;
            if (out_data_valid !== 1'b1 || stall_out !== 1'b1 || vx_out[0] !== -16'sd2048 || area2 !== 32'sd20580) begin
                tests_failed++;
                $display("FAIL hold_stable%0d: valid=%b stall=%b vx0=%0d area2=%0d", i, out_data_valid, stall_out, vx_out[0], area2);
            end
        end
        stall_in = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (out_data_valid !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: valid=%b stall=%b expected 0 0", out_data_valid, stall_out);
        end
    endtask

    task automatic test_reset_mid();
        accept_tri(10, 10, 20, 10, 10, 20, 1'b1);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({stall_out, out_data_valid, done_out, token_only} !== 4'b0000 ||
            area2 !== 32'sd0 || edge_c[0] !== 32'sd0 || vx_out[1] !== 16'sd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: flags=%b area2=%0d c0=%0d vx1=%0d expected 0", {stall_out, out_data_valid, done_out, token_only},
                     area2, edge_c[0], vx_out[1]);
        end
        #2;
        reset = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        tests_run++;
        if (out_data_valid !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_no_output: valid=%b stall=%b expected 0 0", out_data_valid, stall_out);
        end
        test_basic("after_reset");
    endtask

    initial begin
        reset = 1'b0;
        input_data_valid = 1'b0;
        done_in = 1'b0;
        stall_in = 1'b0;
        color_in1 = 24'd0; color_in2 = 24'd0; color_in3 = 24'd0;
        for (int i = 0; i < 4; i++) begin
            x_in[i] = 32'sd0; y_in[i] = 32'sd0; z_in[i] = 32'd0;
        end
        test_reset();
        test_basic("basic");
        test_backface();
        test_token();
        test_clamp();
        test_offscreen();
        test_saturate_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
